// File: rtl/ln_norm_sequencer_pkg.sv
// Shared definitions for the linearizer/normalizer transaction controller:
// FSM state encoding, default watchdog limit and a counter-width helper.
package ln_norm_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Width of a counter that must be able to hold the value `limit`.
  function automatic int wd_count_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ln_norm_sequencer_watchdog.sv
// WAIT-phase watchdog: cleared on load, counts enabled cycles and saturates
// at LIMIT. `expired` is high while the count sits at LIMIT.
module ln_norm_watchdog
  import ln_norm_sequencer_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = wd_count_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_r;
  logic          at_limit_s;

  assign at_limit_s = (count_r == LIMIT_C);
  assign expired    = at_limit_s;

  // Cycle counter: clear on load, increment while enabled, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (en && !at_limit_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ln_norm_sequencer.sv
// Transaction controller for the I/V linearizer/normalizer datapath.
// Accepts one float pair, resets and starts both datapath channels, collects
// their acks (sticky, first-ack capture) and returns the fixed-point pair.
// A watchdog turns a hung datapath into a flagged, zero-filled result.
module ln_norm_sequencer
  import ln_norm_sequencer_pkg::*;
#(
  parameter int W              = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_i,
  input  logic [W-1:0] in_v,
  output logic [W-1:0] ln_i,
  output logic [W-1:0] ln_v,
  output logic         ln_rst_fsm,
  output logic         ln_begin_i,
  output logic         ln_begin_v,
  input  logic         ln_ack_i,
  input  logic         ln_ack_v,
  input  logic [W-1:0] ln_result_i,
  input  logic [W-1:0] ln_result_v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_v,
  output logic         out_timeout,
  output logic         busy
);

  state_e state_r, state_next_s;

  logic         accept_s, in_wait_s;
  logic         hit_i_s, hit_v_s, both_s, expired_s;
  logic         flag_i_r, flag_v_r;
  logic [W-1:0] ln_i_r, ln_v_r, out_i_r, out_v_r;
  logic         out_timeout_r;

  logic in_ready_r, busy_r, rst_fsm_r, begin_r, out_valid_r;
  logic in_ready_next_s, busy_next_s, rst_fsm_next_s, begin_next_s, out_valid_next_s;

  assign accept_s  = (state_r == ST_IDLE) && in_valid;
  assign in_wait_s = (state_r == ST_WAIT);
  // First cycle a channel's ack is seen in WAIT; later cycles never recapture.
  assign hit_i_s   = in_wait_s && ln_ack_i && !flag_i_r;
  assign hit_v_s   = in_wait_s && ln_ack_v && !flag_v_r;
  // Completion counts acks arriving this cycle, so same-cycle acks finish at once.
  assign both_s    = (flag_i_r || ln_ack_i) && (flag_v_r || ln_ack_v);

  ln_norm_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept_s),
    .en      (in_wait_s),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_CLR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLR:   state_next_s = ST_START;
      ST_START: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (both_s || expired_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop.
  always_comb begin
    in_ready_next_s  = 1'b0;
    busy_next_s      = 1'b1;
    rst_fsm_next_s   = 1'b0;
    begin_next_s     = 1'b0;
    out_valid_next_s = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        in_ready_next_s = 1'b1;
        busy_next_s     = 1'b0;
      end
      ST_CLR:   rst_fsm_next_s   = 1'b1;
      ST_START: begin_next_s     = 1'b1;
      ST_WAIT:  busy_next_s      = 1'b1;
      ST_DONE:  out_valid_next_s = 1'b1;
      default: begin
        in_ready_next_s = 1'b0;
        busy_next_s     = 1'b1;
      end
    endcase
  end

  // Control output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      rst_fsm_r   <= 1'b0;
      begin_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_next_s;
      busy_r      <= busy_next_s;
      rst_fsm_r   <= rst_fsm_next_s;
      begin_r     <= begin_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

  // Operand latch, sticky ack flags and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ln_i_r        <= '0;
      ln_v_r        <= '0;
      flag_i_r      <= 1'b0;
      flag_v_r      <= 1'b0;
      out_i_r       <= '0;
      out_v_r       <= '0;
      out_timeout_r <= 1'b0;
    end else if (accept_s) begin
      // Results are pre-zeroed so a channel that never acks reports 0.
      ln_i_r        <= in_i;
      ln_v_r        <= in_v;
      flag_i_r      <= 1'b0;
      flag_v_r      <= 1'b0;
      out_i_r       <= '0;
      out_v_r       <= '0;
      out_timeout_r <= 1'b0;
    end else if (in_wait_s) begin
      if (hit_i_s) begin
        flag_i_r <= 1'b1;
        out_i_r  <= ln_result_i;
      end else begin
        flag_i_r <= flag_i_r;
      end
      if (hit_v_s) begin
        flag_v_r <= 1'b1;
        out_v_r  <= ln_result_v;
      end else begin
        flag_v_r <= flag_v_r;
      end
      if (!both_s && expired_s) begin
        out_timeout_r <= 1'b1;
      end else begin
        out_timeout_r <= out_timeout_r;
      end
    end else begin
      flag_i_r <= flag_i_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign ln_rst_fsm  = rst_fsm_r;
  assign ln_begin_i  = begin_r;
  assign ln_begin_v  = begin_r;
  assign out_valid   = out_valid_r;
  assign ln_i        = ln_i_r;
  assign ln_v        = ln_v_r;
  assign out_i       = out_i_r;
  assign out_v       = out_v_r;
  assign out_timeout = out_timeout_r;

endmodule

// File: tb/tb_ln_norm_sequencer.sv
// Self-checking bench for ln_norm_sequencer. Each transaction is described by
// ack delays (in cycles from WAIT entry) and result values; the expected
// latency, captured data and timeout flag follow from the transaction rules.
module tb_ln_norm_sequencer;

  localparam int W     = 32;
  localparam int T     = 20;
  localparam int NEVER = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_i = '0, in_v = '0;
  logic [W-1:0] ln_i, ln_v;
  logic         ln_rst_fsm, ln_begin_i, ln_begin_v;
  logic         ln_ack_i = 1'b0, ln_ack_v = 1'b0;
  logic [W-1:0] ln_result_i = '0, ln_result_v = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_i, out_v;
  logic         out_timeout, busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ln_norm_sequencer #(.W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_v(in_v),
    .ln_i(ln_i), .ln_v(ln_v), .ln_rst_fsm(ln_rst_fsm),
    .ln_begin_i(ln_begin_i), .ln_begin_v(ln_begin_v),
    .ln_ack_i(ln_ack_i), .ln_ack_v(ln_ack_v),
    .ln_result_i(ln_result_i), .ln_result_v(ln_result_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_v(out_v), .out_timeout(out_timeout), .busy(busy)
  );

  // One full transaction. di/dv: ack delay from WAIT entry (NEVER = no ack).
  // hold: cycles OUT_READY stays low in DONE. stale_i: ack_i already high
  // through CLR/START. abort_at: cycle after accept at which RST_N drops (0 = none).
  task automatic drive_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int di, input int dv,
                           input logic [W-1:0] ri, input logic [W-1:0] rv,
                           input int hold, input bit stale_i, input int abort_at);
    int m, fin, vcyc, widx;
    logic [W-1:0] exp_i, exp_v;
    logic exp_to;
    logic [5:0] exp_ctl, obs_ctl;
    // Reference model: transaction ends at the later ack, capped by the watchdog.
    m      = (di > dv) ? di : dv;
    fin    = (m <= T) ? m : T;
    vcyc   = 3 + fin + 1;
    exp_i  = (di <= T) ? ri : '0;
    exp_v  = (dv <= T) ? rv : '0;
    exp_to = (m > T);

    in_i = a; in_v = b; in_valid = 1'b1; out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_i = $urandom; in_v = $urandom;

    for (int cyc = 1; cyc <= 200; cyc++) begin
      widx = cyc - 3;
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ln_rst_fsm, ln_begin_i, ln_begin_v, out_valid, out_timeout, busy} !== 6'b0 ||
            {out_i, out_v, ln_i, ln_v} !== {(4*W){1'b0}}) begin
          tests_failed++;
          $display("FAIL async_reset: ctl=%b out_i=%h out_v=%h ln_i=%h ln_v=%h required all 0",
                   {ln_rst_fsm, ln_begin_i, ln_begin_v, out_valid, out_timeout, busy},
                   out_i, out_v, ln_i, ln_v);
        end
        ln_ack_i = 1'b0; ln_ack_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({in_ready, busy} !== 2'b10) begin
          tests_failed++;
          $display("FAIL post_reset_ready: in_ready,busy=%b required 10", {in_ready, busy});
        end
        return;
      end

      exp_ctl = {cyc == 1, cyc == 2, cyc == 2, cyc == vcyc, 1'b0, 1'b1};
      obs_ctl = {ln_rst_fsm, ln_begin_i, ln_begin_v, out_valid, in_ready, busy};
      tests_run++;
      if (obs_ctl !== exp_ctl) begin
        tests_failed++;
        $display("FAIL ctl_cycle%0d: rst,bi,bv,valid,ready,busy=%b required %b", cyc, obs_ctl, exp_ctl);
      end
      tests_run++;
      if ({ln_i, ln_v} !== {a, b}) begin
        tests_failed++;
        $display("FAIL operands_cycle%0d: ln_i=%h ln_v=%h required %h %h", cyc, ln_i, ln_v, a, b);
      end
      if (cyc <= 3) begin
        tests_run++;
        if ({out_i, out_v, out_timeout} !== {(2*W+1){1'b0}}) begin
          tests_failed++;
          $display("FAIL early_capture_cycle%0d: out_i=%h out_v=%h to=%b required 0", cyc, out_i, out_v, out_timeout);
        end
      end
      if (cyc == vcyc) break;

      // Datapath model: level acks, result valid only on the first ack cycle.
      ln_ack_i    = (widx >= di) || (stale_i && widx < 0);
      ln_result_i = (widx == di) ? ri : W'($urandom);
      ln_ack_v    = (widx >= dv);
      ln_result_v = (widx == dv) ? rv : W'($urandom);
      @(negedge clk);
    end

    for (int h = 0; h <= hold; h++) begin
      tests_run++;
      if ({out_valid, in_ready, busy, out_timeout, out_i, out_v} !== {3'b101, exp_to, exp_i, exp_v}) begin
        tests_failed++;
        $display("FAIL result_hold%0d: valid,ready,busy=%b to=%b out_i=%h out_v=%h required 101 %b %h %h",
                 h, {out_valid, in_ready, busy}, out_timeout, out_i, out_v, exp_to, exp_i, exp_v);
      end
      ln_ack_i = $urandom; ln_ack_v = $urandom;
      ln_result_i = $urandom; ln_result_v = $urandom;
      if (h == hold) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    ln_ack_i = 1'b0; ln_ack_v = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL return_idle: ready,valid,busy=%b required 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ln_rst_fsm, ln_begin_i, ln_begin_v, out_valid, out_timeout, busy} !== 6'b0 ||
        {out_i, out_v, ln_i, ln_v} !== {(4*W){1'b0}}) begin
      tests_failed++;
      $display("FAIL reset_values: ctl=%b out_i=%h out_v=%h ln_i=%h ln_v=%h required all 0",
               {ln_rst_fsm, ln_begin_i, ln_begin_v, out_valid, out_timeout, busy}, out_i, out_v, ln_i, ln_v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({in_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_ready: in_ready,busy=%b required 10", {in_ready, busy});
    end
  endtask

  task automatic test_normal();
    drive_txn(32'h41200000, 32'h40A00000, 10, 3, 32'h00012345, 32'h000ABCDE, 0, 1'b0, 0);
  endtask

  task automatic test_simultaneous();
    drive_txn(32'h3F800000, 32'h40000000, 0, 0, 32'h00000011, 32'h00000022, 0, 1'b0, 0);
  endtask

  task automatic test_timeout();
    drive_txn(32'h42C80000, 32'h41F00000, NEVER, 4, 32'hDEADBEEF, 32'h00000777, 1, 1'b0, 0);
    drive_txn(32'h42C80001, 32'h41F00001, T, T, 32'h0000AAAA, 32'h0000BBBB, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    drive_txn(32'h40400000, 32'h40800000, 2, 5, 32'h00003333, 32'h00004444, 50, 1'b0, 0);
  endtask

  task automatic test_stale_ack();
    ln_ack_i = 1'b1;
    drive_txn(32'h40E00000, 32'h41000000, 0, 1, 32'h00005555, 32'h00006666, 0, 1'b1, 0);
  endtask

  task automatic test_reset_mid_wait();
    drive_txn(32'h41100000, 32'h41200000, NEVER, NEVER, 32'h1, 32'h2, 0, 1'b0, 3 + 5);
    drive_txn(32'h41300000, 32'h41400000, 1, 2, 32'h00007777, 32'h00008888, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back_random();
    int di, dv;
    for (int n = 0; n < 30; n++) begin
      di = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 24));
      dv = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 24));
      drive_txn(W'($urandom), W'($urandom), di, dv, W'($urandom), W'($urandom),
                int'($urandom_range(0, 3)), 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_simultaneous();
    test_timeout();
    test_backpressure();
    test_stale_ack();
    test_reset_mid_wait();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ln_norm_sequencer.md
# ln_norm_sequencer

Transaction controller for the linearizer/normalizer datapath (I-channel log linearizer → float-to-fixed; V-channel float-to-fixed). It accepts one float sample pair (I, V) per valid/ready handshake and holds the operands stable on the datapath inputs. It resets the datapath sub-FSMs, fires both begin strobes, collects the two independent ACKs, and captures both fixed-point results. It returns the results on a valid/ready output, and a watchdog converts a hung datapath into a flagged, zero-filled result instead of a deadlock.

## Interface
Parameters:
- W, 32, operand/result width
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (1..65535)

Ports:
- CLK  in  1  system clock; single clock domain
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  sample pair available
- IN_READY  out  1  controller can accept a sample (high only in IDLE)
- IN_I, IN_V  in  W  float current / voltage operands
- LN_I, LN_V  out  W  operands to datapath, registered at accept
- LN_RST_FSM  out  1  datapath FSM reset strobe (active-high)
- LN_BEGIN_I, LN_BEGIN_V  out  1  datapath begin strobes
- LN_ACK_I, LN_ACK_V  in  1  datapath completion flags (level)
- LN_RESULT_I, LN_RESULT_V  in  W  datapath fixed-point results
- OUT_VALID  out  1  result pair valid
- OUT_READY  in  1  consumer accepts result
- OUT_I, OUT_V  out  W  captured fixed-point results
- OUT_TIMEOUT  out  1  qualifies OUT_VALID: watchdog expired
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CLR, START, WAIT, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID, latch IN_I/IN_V into LN_I/LN_V, clear the ack flags and the timeout counter, and go to CLR.
- CLR: LN_RST_FSM=1 for exactly one cycle, then START.
- START: LN_BEGIN_I=LN_BEGIN_V=1 for exactly one cycle, then WAIT.
- WAIT:
  - Sample LN_ACK_I/LN_ACK_V every cycle.
  - On the first cycle an ack is seen, set its sticky flag and capture the corresponding LN_RESULT_x into OUT_x.
  - Later ack cycles do not recapture.
  - When both flags are set (including the case where both arrive in the same cycle), go to DONE with OUT_TIMEOUT=0.
  - The counter increments every WAIT cycle. If it reaches TIMEOUT_CYCLES with either flag clear, go to DONE with OUT_TIMEOUT=1; a channel that never acked reports 0.
- DONE:
  - OUT_VALID=1.
  - OUT_I/OUT_V/OUT_TIMEOUT are held until OUT_READY is high, then the state returns to IDLE.
- Acks asserted during CLR or START are ignored; only WAIT samples them.
- LN_I/LN_V stay constant from accept until the next accept.
- The datapath is never re-begun without passing through CLR, so stale sticky ACKs from a previous or timed-out transaction are cleared before each start.
- Counter width: clog2(TIMEOUT_CYCLES+1); it does not wrap.

## Timing
- Reset values (async on RST_N low):
  - state=IDLE.
  - All strobes 0; OUT_VALID=0, OUT_TIMEOUT=0.
  - OUT_I/OUT_V/LN_I/LN_V=0.
  - IN_READY=1 after reset release.
- Accept at edge k (IN_VALID & IN_READY):
  - LN_RST_FSM high in cycle k+1.
  - LN_BEGIN_x high in cycle k+2.
  - WAIT begins at cycle k+3.
- An ack seen in WAIT cycle m gives OUT_VALID=1 from cycle m+1 (registered, no combinational ack→valid path).
- Minimum accept-to-OUT_VALID latency is 4 cycles (acks in the first WAIT cycle).
- Timeout: OUT_VALID rises TIMEOUT_CYCLES+1 cycles after WAIT entry.
- DONE→IDLE takes one edge. IN_READY is low during the handshake cycle, so throughput is at most one sample per 5 cycles.
- RST_N asserted mid-transaction aborts immediately to IDLE. It does not pulse LN_RST_FSM; the next transaction's CLR clears the datapath.
- All outputs are registered.

## Structure
- Shared package: state encoding enum (IDLE, CLR, START, WAIT, DONE) and the default TIMEOUT_CYCLES constant.
- One sub-module is natural: ln_norm_watchdog (load/enable/expired counter). Everything else stays in the single FSM module.

## Test plan
- Normal:
  - IN_I=32'h41200000, IN_V=32'h40A00000.
  - Model ACK_I 10 cycles and ACK_V 3 cycles after the begin strobe, with RESULT_I=32'h00012345 and RESULT_V=32'h000ABCDE.
  - Expect OUT_I/OUT_V equal to those results, OUT_TIMEOUT=0, OUT_VALID 11 cycles after WAIT entry, and exactly one LN_RST_FSM and one begin pulse each.
- Simultaneous acks in the first WAIT cycle: OUT_VALID at accept+4.
- Timeout:
  - TIMEOUT_CYCLES=20; ACK_I never asserts, ACK_V acks with 32'h00000777.
  - Expect OUT_TIMEOUT=1, OUT_I=0, OUT_V=32'h00000777, OUT_VALID at WAIT entry+21.
- Backpressure:
  - Hold OUT_READY=0 for 50 cycles; OUT_VALID and data are stable and IN_READY=0.
  - Release; IN_READY=1 on the next cycle.
- Stale ack:
  - Hold LN_ACK_I=1 through CLR/START of a new transaction; no capture before WAIT.
  - With ack held in WAIT, capture occurs in the first WAIT cycle.
- Reset mid-WAIT: drive RST_N low at WAIT+5; all outputs return to reset values asynchronously, and a following transaction completes normally.
